lcd_char_sequencer: RTL and testbench

Command sequencer in front of `lcd_controller`. It accepts character, cursor and clear/home requests from a host through a small request FIFO and tracks the cursor position. It translates each request into one or two byte transactions on the controller's `rs_in/data_in/strobe_in/done` handshake, inserting DDRAM set-address commands where the HD44780 address map requires them. It sits between application logic (text generators, debug printers) and the existing LCD controller.

---
 rtl/lcd_pkg.sv | 42 ++++
 rtl/lcd_req_fifo.sv | 58 +++++
 rtl/lcd_char_sequencer.sv | 173 +++++++++++++++++
 tb/tb_lcd_char_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared encodings, command bytes and FSM states for the LCD sequencer
package lcd_pkg;

    typedef enum logic [1:0] {
        OP_CHAR   = 2'd0,
        OP_CURSOR = 2'd1,
        OP_CLEAR  = 2'd2,
        OP_HOME   = 2'd3
    } lcd_op_e;

    localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME    = 8'h02;
    localparam logic [7:0] LCD_CMD_SETADDR = 8'h80;
    localparam logic [7:0] LCD_ROW0_BASE   = 8'h00;
    localparam logic [7:0] LCD_ROW1_BASE   = 8'h40;

    localparam int LCD_REQ_W = 15;

    typedef struct packed {
        logic [1:0] op;
        logic       row;
        logic [3:0] col;
        logic [7:0] chr;
    } lcd_req_t;

    typedef enum logic [3:0] {
        S_WAIT_INIT,
        S_IDLE,
        S_ADDR,
        S_ADDR_WAIT,
        S_DATA,
        S_DATA_WAIT,
        S_CMD,
        S_CMD_WAIT,
        S_DELAY
    } seq_state_e;

    function automatic logic [7:0] setaddr_byte(input logic row, input logic [3:0] col);
        return LCD_CMD_SETADDR | (row ? LCD_ROW1_BASE : LCD_ROW0_BASE) | {4'h0, col};
    endfunction

endpackage

// File: rtl/lcd_req_fifo.sv
// rtl/lcd_req_fifo.sv - synchronous request FIFO with full/empty flags
module lcd_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign rdata_o = mem_q[rptr_q];

    // A push on a full cycle is refused even when a pop happens alongside it.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/lcd_char_sequencer.sv
// rtl/lcd_char_sequencer.sv - turns queued char/cursor/clear/home requests into lcd_controller byte transactions
module lcd_char_sequencer
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int COLS         = 16,
    parameter int CLEAR_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_done,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic       req_row,
    input  logic [3:0] req_col,
    input  logic [7:0] req_char,
    output logic       ctl_rs,
    output logic [7:0] ctl_data,
    output logic       ctl_strobe,
    input  logic       ctl_done,
    output logic       busy,
    output logic       cur_row,
    output logic [3:0] cur_col
);
    localparam logic [3:0] LAST_COL = 4'(COLS - 1);
    localparam int         CW       = $clog2(CLEAR_CYCLES + 1);

    seq_state_e     state_q;
    logic           row_q;
    logic [3:0]     col_q;
    logic           addr_dirty_q;
    logic [7:0]     char_q;
    logic [7:0]     cmd_q;
    logic [CW-1:0]  dly_q;
    logic           ctl_rs_q;
    logic [7:0]     ctl_data_q;
    logic           ctl_strobe_q;

    lcd_req_t       wreq;
    lcd_req_t       head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           pop;

    assign wreq = '{op: req_op, row: req_row, col: req_col, chr: req_char};
    assign pop  = (state_q == S_IDLE) && !fifo_empty && init_done;

    lcd_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (LCD_REQ_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (req_valid),
        .wdata_i (wreq),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign req_ready  = !fifo_full;
    assign busy       = !fifo_empty || !(state_q inside {S_IDLE, S_WAIT_INIT});
    assign ctl_rs     = ctl_rs_q;
    assign ctl_data   = ctl_data_q;
    assign ctl_strobe = ctl_strobe_q;
    assign cur_row    = row_q;
    assign cur_col    = col_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_WAIT_INIT;
            row_q        <= 1'b0;
            col_q        <= 4'h0;
            addr_dirty_q <= 1'b1;
            char_q       <= 8'h00;
            cmd_q        <= 8'h00;
            dly_q        <= '0;
            ctl_rs_q     <= 1'b0;
            ctl_data_q   <= 8'h00;
            ctl_strobe_q <= 1'b0;
        end else if (!init_done) begin
            // Controller re-initialising: its DDRAM address is unknown afterwards.
            state_q      <= S_WAIT_INIT;
            addr_dirty_q <= 1'b1;
            ctl_strobe_q <= 1'b0;
        end else begin
            ctl_strobe_q <= 1'b0;
            case (state_q)
                S_WAIT_INIT: state_q <= S_IDLE;
                S_IDLE: begin
                    if (pop) begin
                        case (lcd_op_e'(head.op))
                            OP_CHAR: begin
                                char_q  <= head.chr;
                                state_q <= addr_dirty_q ? S_ADDR : S_DATA;
                            end
                            OP_CURSOR: begin
                                row_q        <= head.row;
                                col_q        <= (head.col > LAST_COL) ? LAST_COL : head.col;
                                addr_dirty_q <= 1'b1;
                            end
                            OP_CLEAR: begin
                                cmd_q   <= LCD_CMD_CLEAR;
                                state_q <= S_CMD;
                            end
                            default: begin
                                cmd_q   <= LCD_CMD_HOME;
                                state_q <= S_CMD;
                            end
                        endcase
                    end
                end
                S_ADDR: begin
                    ctl_rs_q     <= 1'b0;
                    ctl_data_q   <= setaddr_byte(row_q, col_q);
                    ctl_strobe_q <= 1'b1;
                    state_q      <= S_ADDR_WAIT;
                end
                S_ADDR_WAIT: begin
                    if (ctl_done) begin
                        addr_dirty_q <= 1'b0;
                        state_q      <= S_DATA;
                    end
                end
                S_DATA: begin
                    ctl_rs_q     <= 1'b1;
                    ctl_data_q   <= char_q;
                    ctl_strobe_q <= 1'b1;
                    state_q      <= S_DATA_WAIT;
                end
                S_DATA_WAIT: begin
                    if (ctl_done) begin
                        // End of row: HD44780 rows are not contiguous, so force a re-address.
                        if (col_q == LAST_COL) begin
                            col_q        <= 4'h0;
                            row_q        <= ~row_q;
                            addr_dirty_q <= 1'b1;
                        end else begin
                            col_q <= col_q + 4'h1;
                        end
                        state_q <= S_IDLE;
                    end
                end
                S_CMD: begin
                    ctl_rs_q     <= 1'b0;
                    ctl_data_q   <= cmd_q;
                    ctl_strobe_q <= 1'b1;
                    state_q      <= S_CMD_WAIT;
                end
                S_CMD_WAIT: begin
                    if (ctl_done) begin
                        row_q        <= 1'b0;
                        col_q        <= 4'h0;
                        addr_dirty_q <= 1'b0;
                        dly_q        <= '0;
                        state_q      <= S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (dly_q == CW'(CLEAR_CYCLES - 1)) begin
                        state_q <= S_IDLE;
                    end else begin
                        dly_q <= dly_q + CW'(1);
                    end
                end
                default: state_q <= S_WAIT_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_char_sequencer.sv
// tb/tb_lcd_char_sequencer.sv - directed self-checking bench for lcd_char_sequencer
module tb_lcd_char_sequencer;
    localparam int FIFO_DEPTH   = 4;
    localparam int COLS         = 16;
    localparam int CLEAR_CYCLES = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       init_done = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'd0;
    logic       req_row = 1'b0;
    logic [3:0] req_col = 4'h0;
    logic [7:0] req_char = 8'h00;
    logic       ctl_rs;
    logic [7:0] ctl_data;
    logic       ctl_strobe;
    logic       ctl_done = 1'b0;
    logic       busy;
    logic       cur_row;
    logic [3:0] cur_col;

    int total = 0;
    int bad   = 0;

    logic       hold = 1'b0;
    logic       pending = 1'b0;
    int         wait_cnt = 0;
    logic       rs_log [$];
    logic [7:0] data_log [$];

    lcd_char_sequencer #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .COLS         (COLS),
        .CLEAR_CYCLES (CLEAR_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .init_done  (init_done),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_row    (req_row),
        .req_col    (req_col),
        .req_char   (req_char),
        .ctl_rs     (ctl_rs),
        .ctl_data   (ctl_data),
        .ctl_strobe (ctl_strobe),
        .ctl_done   (ctl_done),
        .busy       (busy),
        .cur_row    (cur_row),
        .cur_col    (cur_col)
    );

    always #5 clk = ~clk;

    // Controller stand-in: logs each strobe and answers with done a few cycles later unless held.
    always @(posedge clk) begin
        ctl_done <= 1'b0;
        if (ctl_strobe) begin
            rs_log.push_back(ctl_rs);
            data_log.push_back(ctl_data);
        end
        if (!rst) begin
            pending <= 1'b0;
        end else if (ctl_strobe) begin
            pending  <= 1'b1;
            wait_cnt <= 2;
        end else if (pending && !hold) begin
            if (wait_cnt == 0) begin
                ctl_done <= 1'b1;
                pending  <= 1'b0;
            end else begin
                wait_cnt <= wait_cnt - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag, input int idx, input logic rs, input logic [7:0] data);
        logic [31:0] obs_rs;
        logic [31:0] obs_data;
        obs_rs   = (idx < rs_log.size()) ? {31'd0, rs_log[idx]} : 32'hDEAD;
        obs_data = (idx < data_log.size()) ? {24'd0, data_log[idx]} : 32'hDEAD;
        check({tag, "_rs"}, obs_rs, {31'd0, rs});
        check({tag, "_data"}, obs_data, {24'd0, data});
    endtask

    task automatic push(input logic [1:0] op, input logic row, input logic [3:0] col, input logic [7:0] chr);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("push_ready_timeout", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_row   = row;
        req_col   = col;
        req_char  = chr;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int b;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_strobe", {31'd0, ctl_strobe}, 32'd0);
        check("rst_rs", {31'd0, ctl_rs}, 32'd0);
        check("rst_data", {24'd0, ctl_data}, 32'h00);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cursor", {27'd0, cur_row, cur_col}, 32'h00);
        rst = 1'b1;

        // Queued while controller still initialising
        push(2'd0, 1'b0, 4'h0, 8'h41);
        repeat (10) @(negedge clk);
        check("init_no_strobe", rs_log.size(), 32'd0);
        check("init_busy", {31'd0, busy}, 32'd1);
        init_done = 1'b1;
        wait_idle(200);
        check("init_count", rs_log.size(), 32'd2);
        check_log("init_addr", 0, 1'b0, 8'h80);
        check_log("init_char", 1, 1'b1, 8'h41);
        check("init_cursor", {27'd0, cur_row, cur_col}, 32'h01);

        // Row wrap across 17 characters
        b = rs_log.size();
        push(2'd1, 1'b0, 4'h0, 8'h00);
        for (int i = 0; i < 17; i++) push(2'd0, 1'b0, 4'h0, 8'(8'h30 + i));
        wait_idle(2000);
        check("wrap_count", rs_log.size() - b, 32'd19);
        check_log("wrap_addr0", b, 1'b0, 8'h80);
        for (int i = 0; i < 16; i++) check_log("wrap_char", b + 1 + i, 1'b1, 8'(8'h30 + i));
        check_log("wrap_addr1", b + 17, 1'b0, 8'hC0);
        check_log("wrap_char17", b + 18, 1'b1, 8'h40);
        check("wrap_cursor", {27'd0, cur_row, cur_col}, 32'h11);

        // Explicit cursor placement
        b = rs_log.size();
        push(2'd1, 1'b1, 4'h5, 8'h00);
        push(2'd0, 1'b0, 4'h0, 8'h5A);
        push(2'd0, 1'b0, 4'h0, 8'h5B);
        wait_idle(500);
        check("cur_count", rs_log.size() - b, 32'd3);
        check_log("cur_addr", b, 1'b0, 8'hC5);
        check_log("cur_char0", b + 1, 1'b1, 8'h5A);
        check_log("cur_char1", b + 2, 1'b1, 8'h5B);
        check("cur_cursor", {27'd0, cur_row, cur_col}, 32'h17);

        // Clear with post-command delay, then home
        b = rs_log.size();
        push(2'd2, 1'b0, 4'h0, 8'h00);
        n = 0;
        while (!ctl_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("clr_done_seen", {31'd0, ctl_done}, 32'd1);
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy || n > 1000) break;
            n++;
        end
        check("clr_delay", n, CLEAR_CYCLES);
        check_log("clr_cmd", b, 1'b0, 8'h01);
        check("clr_cursor", {27'd0, cur_row, cur_col}, 32'h00);
        push(2'd3, 1'b0, 4'h0, 8'h00);
        wait_idle(500);
        check_log("home_cmd", b + 1, 1'b0, 8'h02);
        push(2'd0, 1'b0, 4'h0, 8'h61);
        wait_idle(500);
        check("clr_count", rs_log.size() - b, 32'd3);
        check_log("clr_char", b + 2, 1'b1, 8'h61);

        // FIFO full while controller stalls
        b = rs_log.size();
        hold = 1'b1;
        for (int i = 0; i < FIFO_DEPTH + 1; i++) push(2'd0, 1'b0, 4'h0, 8'(8'h70 + i));
        @(negedge clk);
        check("full_ready", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_char  = 8'h75;
        @(negedge clk);
        req_valid = 1'b0;
        check("full_ready2", {31'd0, req_ready}, 32'd0);
        hold = 1'b0;
        wait_idle(1000);
        check("full_count", rs_log.size() - b, 32'd5);
        for (int i = 0; i < 5; i++) check_log("full_order", b + i, 1'b1, 8'(8'h70 + i));
        check("full_cursor", {27'd0, cur_row, cur_col}, 32'h06);

        // Async reset during DATA_WAIT
        b = rs_log.size();
        hold = 1'b1;
        push(2'd0, 1'b0, 4'h0, 8'h7A);
        n = 0;
        while (rs_log.size() == b && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_strobe_seen", rs_log.size() - b, 32'd1);
        push(2'd0, 1'b0, 4'h0, 8'h7B);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_strobe", {31'd0, ctl_strobe}, 32'd0);
        check("arst_rs", {31'd0, ctl_rs}, 32'd0);
        check("arst_data", {24'd0, ctl_data}, 32'h00);
        check("arst_ready", {31'd0, req_ready}, 32'd1);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_cursor", {27'd0, cur_row, cur_col}, 32'h00);
        hold = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("arst_fifo_empty", rs_log.size() - b, 32'd1);
        b = rs_log.size();
        push(2'd0, 1'b0, 4'h0, 8'h41);
        wait_idle(500);
        check("arst_count", rs_log.size() - b, 32'd2);
        check_log("arst_addr", b, 1'b0, 8'h80);
        check_log("arst_char", b + 1, 1'b1, 8'h41);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
